// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: issues one instruction-memory request at a time at the
// current PC. It decides when the external PC register loads and which next-PC
// source the PC mux selects. Redirects from execute that arrive while a fetch
// is in flight are parked until the response returns, and the stale
// instruction is then flushed.
module pc_fetch_ctrl #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic                     branch_taken,
    input  logic                     jalr,
    input  logic                     stall,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic                     pc_en,
    output logic [1:0]               pc_src,
    output logic                     instr_valid,
    output logic                     flush_f,
    output logic [COUNT_WIDTH-1:0]   redirect_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JALR   = 2'b10;

    state_t                   state_reg;
    state_t                   state_next;
    logic                     pend_valid_reg;
    logic [1:0]               pend_src_reg;
    logic [COUNT_WIDTH-1:0]   count_reg;

    // A jalr and a taken branch in the same cycle cannot both be honoured;
    // the jalr is the younger-resolved one and takes priority.
    logic       redir;
    logic [1:0] redir_src;
    assign redir     = jalr | branch_taken;
    assign redir_src = jalr ? SRC_JALR : SRC_BRANCH;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT: state_next = REQ;
            REQ: begin
                // A redirect retargets the unaccepted request in place.
                if (!redir && imem_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    if (redir || pend_valid_reg || !stall) begin
                        state_next = REQ;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir || !stall) begin
                    state_next = REQ;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = '0;
        pc_en       = 1'b0;
        pc_src      = SRC_SEQ;
        instr_valid = 1'b0;
        flush_f     = 1'b0;
        case (state_reg)
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (redir) begin
                    pc_en  = 1'b1;
                    pc_src = redir_src;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    if (redir || pend_valid_reg) begin
                        // The returning instruction is on the wrong path.
                        flush_f = 1'b1;
                        pc_en   = 1'b1;
                        pc_src  = redir ? redir_src : pend_src_reg;
                    end else begin
                        instr_valid = 1'b1;
                        pc_en       = !stall;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    flush_f = 1'b1;
                    pc_en   = 1'b1;
                    pc_src  = redir_src;
                end else begin
                    instr_valid = 1'b1;
                    pc_en       = !stall;
                end
            end
            default: ;
        endcase
    end

    // Pending redirect: latest redirect seen while waiting for the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_reg <= 1'b0;
            pend_src_reg   <= SRC_SEQ;
        end else if (state_reg == RESP) begin
            if (imem_rvalid) begin
                pend_valid_reg <= 1'b0;
                pend_src_reg   <= SRC_SEQ;
            end else if (redir) begin
                pend_valid_reg <= 1'b1;
                pend_src_reg   <= redir_src;
            end
        end else begin
            pend_valid_reg <= 1'b0;
            pend_src_reg   <= SRC_SEQ;
        end
    end

    // Saturating count of PC loads from a non-sequential source
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (pc_en && (pc_src != SRC_SEQ) && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign redirect_count = count_reg;

endmodule
